cla_seq_ctrl: RTL and testbench

- Sequencing controller that builds a DATA_W-bit add/subtract from one shared 16-bit carry-lookahead slice (cla_16).
- The slice is time-multiplexed over DATA_W/16 cycles, least significant slice first; carry is registered between passes.
- Two requesters (e.g. ALU path and address/PC-increment path) share the unit through a round-robin arbiter with a req/gnt/done handshake.
- Sits beside the ALU, replacing a full-width adder where area matters more than latency.

---
 rtl/cla_seq_pkg.sv | 20 ++
 rtl/cla_16.sv | 44 ++++
 rtl/rr_arb_2.sv | 35 +++
 rtl/cla_seq_ctrl.sv | 132 +++++++++++++
 tb/tb_cla_seq_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cla_seq_pkg.sv
// Shared constants for the sequential carry-lookahead add/subtract controller.
// Optional status flags are enabled by defining CLA_SEQ_FLAGS_EN.
package cla_seq_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic REQ_0 = 1'b0;
    localparam logic REQ_1 = 1'b1;

    function automatic int num_slices(input int data_w);
        return data_w / SLICE_W;
    endfunction

endpackage

// File: rtl/cla_16.sv
// 16-bit carry-lookahead adder: four 4-bit groups with a lookahead carry unit.
module cla_16 (
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic        in_cin,
    output logic [15:0] out_sum,
    output logic        out_cout,
    output logic        out_pg,
    output logic        out_gg
);

    logic [15:0] w_g, w_p, w_c;
    logic [3:0]  w_gg, w_gp, w_cg;

    always_comb begin
        // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
        w_g  = in_a & in_b;
        w_p  = in_a ^ in_b;
        w_c  = '0;
        for (int j = 0; j < 4; j++) begin
            w_gp[j] = &w_p[4*j +: 4];
            w_gg[j] = w_g[4*j+3]
                    | (w_p[4*j+3] & w_g[4*j+2])
                    | (w_p[4*j+3] & w_p[4*j+2] & w_g[4*j+1])
                    | (w_p[4*j+3] & w_p[4*j+2] & w_p[4*j+1] & w_g[4*j]);
        end
        w_cg[0] = in_cin;
        w_cg[1] = w_gg[0] | (w_gp[0] & in_cin);
        w_cg[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & in_cin);
        w_cg[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                | (w_gp[2] & w_gp[1] & w_gp[0] & in_cin);
        out_gg  = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0]);
        out_pg  = &w_gp;
        out_cout = out_gg | (out_pg & in_cin);
        for (int j = 0; j < 4; j++) begin
            w_c[4*j] = w_cg[j];
            for (int k = 1; k < 4; k++)
                w_c[4*j+k] = w_g[4*j+k-1] | (w_p[4*j+k-1] & w_c[4*j+k-1]);
        end
        out_sum = w_p ^ w_c;
    end

endmodule

// File: rtl/rr_arb_2.sv
// Two-way round-robin arbiter; combinational grant, pointer moves when a grant is accepted.
module rr_arb_2
    import cla_seq_pkg::*;
(
    input  logic       in_clk,
    input  logic       in_reset,
    input  logic       in_en,
    input  logic [1:0] in_req,
    output logic [1:0] out_gnt
);

    logic r_last;

    always_comb begin
        out_gnt = 2'b00;
        if (in_en) begin
            if (in_req == 2'b01)
                out_gnt = 2'b01;
            else if (in_req == 2'b10)
                out_gnt = 2'b10;
            else if (in_req == 2'b11)
                out_gnt = (r_last == REQ_0) ? 2'b10 : 2'b01;
        end
    end

    // Reset records requester 1 as last served so requester 0 wins the first tie.
    always_ff @(posedge in_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (in_reset)
            r_last <= REQ_1;
        else if (|out_gnt)
            r_last <= out_gnt[1];
    end

endmodule

// File: rtl/cla_seq_ctrl.sv
// DATA_W-bit add/subtract built by running one cla_16 slice LSB-first over DATA_W/16 cycles.
// Define CLA_SEQ_FLAGS_EN to add the out_overflow / out_zero status ports.
module cla_seq_ctrl
    import cla_seq_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              in_clk,
    input  logic              in_reset,
    input  logic              in_req_0,
    input  logic              in_req_1,
    input  logic [DATA_W-1:0] in_x_0,
    input  logic [DATA_W-1:0] in_x_1,
    input  logic [DATA_W-1:0] in_y_0,
    input  logic [DATA_W-1:0] in_y_1,
    input  logic              in_sub_0,
    input  logic              in_sub_1,
    output logic              out_gnt_0,
    output logic              out_gnt_1,
    output logic              out_busy,
    output logic              out_done,
    output logic              out_done_id,
    output logic [DATA_W-1:0] out_result,
`ifdef CLA_SEQ_FLAGS_EN
    output logic              out_overflow,
    output logic              out_zero,
`endif
    output logic              out_carry
);

    localparam int NUM_SLICES = num_slices(DATA_W);
    localparam int CNT_W      = $clog2(NUM_SLICES);

    if ((DATA_W % SLICE_W) != 0 || DATA_W < 32) begin : g_bad_width
        $error("cla_seq_ctrl: DATA_W must be a multiple of 16 and at least 32");
    end

    state_t              r_state;
    logic [DATA_W-1:0]   r_x, r_y, r_result;
    logic                r_cin, r_owner, r_carry_out, r_done_id;
    logic [CNT_W-1:0]    r_cnt;
    logic [1:0]          w_gnt;
    logic [SLICE_W-1:0]  w_sum;
    logic                w_cout, w_last;
    logic [DATA_W-1:0]   w_result_next;
    logic                w_unused_pg, w_unused_gg;

    rr_arb_2 u_arb (
        .in_clk   (in_clk),
        .in_reset (in_reset),
        .in_en    (r_state == IDLE),
        .in_req   ({in_req_1, in_req_0}),
        .out_gnt  (w_gnt)
    );

    cla_16 u_slice (
        .in_a     (r_x[r_cnt*SLICE_W +: SLICE_W]),
        .in_b     (r_y[r_cnt*SLICE_W +: SLICE_W]),
        .in_cin   (r_cin),
        .out_sum  (w_sum),
        .out_cout (w_cout),
        .out_pg   (w_unused_pg),
        .out_gg   (w_unused_gg)
    );

    assign w_last = (r_cnt == CNT_W'(NUM_SLICES - 1));

    always_comb begin
        w_result_next = r_result;
        w_result_next[r_cnt*SLICE_W +: SLICE_W] = w_sum;
    end

    // Y is inverted and carry-in preset to 1 at grant time, turning subtract into X + ~Y + 1.
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            r_state     <= IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_cin       <= 1'b0;
            r_cnt       <= '0;
            r_owner     <= REQ_0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_done_id   <= REQ_0;
`ifdef CLA_SEQ_FLAGS_EN
            out_overflow <= 1'b0;
            out_zero     <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_gnt) begin
                        r_x     <= w_gnt[1] ? in_x_1 : in_x_0;
                        r_y     <= w_gnt[1] ? (in_sub_1 ? ~in_y_1 : in_y_1)
                                            : (in_sub_0 ? ~in_y_0 : in_y_0);
                        r_cin   <= w_gnt[1] ? in_sub_1 : in_sub_0;
                        r_owner <= w_gnt[1];
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_result <= w_result_next;
                    r_cin    <= w_cout;
                    if (w_last) begin
                        r_carry_out <= w_cout;
                        r_done_id   <= r_owner;
`ifdef CLA_SEQ_FLAGS_EN
                        out_overflow <= (r_x[DATA_W-1] == r_y[DATA_W-1])
                                     && (w_sum[SLICE_W-1] != r_x[DATA_W-1]);
                        out_zero     <= (w_result_next == '0);
`endif
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_gnt_0   = w_gnt[0];
    assign out_gnt_1   = w_gnt[1];
    assign out_busy    = (r_state != IDLE);
    assign out_done    = (r_state == DONE);
    assign out_done_id = r_done_id;
    assign out_result  = r_result;
    assign out_carry   = r_carry_out;

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Directed bench for cla_seq_ctrl: scoreboard of expected results pushed at grant, popped at done.
module tb_cla_seq_ctrl;

    localparam int W   = 32;
    localparam int W48 = 48;
    localparam int LAT = W / 16 + 1;

    typedef struct {
        logic [W-1:0] result;
        logic         carry;
        logic         id;
        logic         ovf;
        logic         zero;
        int           t;
    } exp_t;

    exp_t sb[$];
    int   n_asserts = 0;
    int   n_fail    = 0;
    int   cyc       = 0;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_0, req_1, sub_0, sub_1;
    logic [W-1:0]  x_0, x_1, y_0, y_1, result;
    logic          gnt_0, gnt_1, busy, done, done_id, carry;
    logic          ovf, zero;

    logic          b_req_0, b_sub_0;
    logic [W48-1:0] b_x_0, b_y_0, b_result;
    logic          b_gnt_0, b_gnt_1, b_busy, b_done, b_done_id, b_carry;
    logic          b_ovf, b_zero;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cla_seq_ctrl #(.DATA_W(W)) dut (
        .in_clk(clk), .in_reset(reset),
        .in_req_0(req_0), .in_req_1(req_1),
        .in_x_0(x_0), .in_x_1(x_1), .in_y_0(y_0), .in_y_1(y_1),
        .in_sub_0(sub_0), .in_sub_1(sub_1),
        .out_gnt_0(gnt_0), .out_gnt_1(gnt_1), .out_busy(busy), .out_done(done),
        .out_done_id(done_id), .out_result(result),
`ifdef CLA_SEQ_FLAGS_EN
        .out_overflow(ovf), .out_zero(zero),
`endif
        .out_carry(carry)
    );

    cla_seq_ctrl #(.DATA_W(W48)) dut48 (
        .in_clk(clk), .in_reset(reset),
        .in_req_0(b_req_0), .in_req_1(1'b0),
        .in_x_0(b_x_0), .in_x_1('0), .in_y_0(b_y_0), .in_y_1('0),
        .in_sub_0(b_sub_0), .in_sub_1(1'b0),
        .out_gnt_0(b_gnt_0), .out_gnt_1(b_gnt_1), .out_busy(b_busy), .out_done(b_done),
        .out_done_id(b_done_id), .out_result(b_result),
`ifdef CLA_SEQ_FLAGS_EN
        .out_overflow(b_ovf), .out_zero(b_zero),
`endif
        .out_carry(b_carry)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic sub, input logic id);
        exp_t         e;
        logic [W-1:0] yp;
        logic [W:0]   s;
        yp       = sub ? ~y : y;
        s        = {1'b0, x} + {1'b0, yp} + {{W{1'b0}}, sub};
        e.result = s[W-1:0];
        e.carry  = s[W];
        e.id     = id;
        e.ovf    = (x[W-1] == yp[W-1]) && (s[W-1] != x[W-1]);
        e.zero   = (s[W-1:0] == '0);
        e.t      = 0;
        return e;
    endfunction

    task automatic drive(input logic k, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic sub);
        if (k) begin
            req_1 = 1'b1; x_1 = x; y_1 = y; sub_1 = sub;
        end else begin
            req_0 = 1'b1; x_0 = x; y_0 = y; sub_0 = sub;
        end
    endtask

    task automatic release_reqs();
        req_0 = 1'b0;
        req_1 = 1'b0;
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the grant.
    task automatic req_op(input logic k, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic sub);
        logic seen = 1'b0;
        exp_t e;
        drive(k, x, y, sub);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = k ? gnt_1 : gnt_0;
        end
        check("gnt_seen", seen, 1);
        if (seen) begin
            check("gnt_other_low", k ? gnt_0 : gnt_1, 0);
            e   = model(x, y, sub, k);
            e.t = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        release_reqs();
    endtask

    task automatic compare_done(input string tag);
        exp_t e;
        check({tag, "_busy_in_done"}, busy, 1);
        check({tag, "_no_gnt_in_done"}, {gnt_1, gnt_0}, 0);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            check({tag, "_latency"}, cyc - e.t, LAT);
            check({tag, "_result"}, result, e.result);
            check({tag, "_carry"}, carry, e.carry);
            check({tag, "_done_id"}, done_id, e.id);
`ifdef CLA_SEQ_FLAGS_EN
            check({tag, "_overflow"}, ovf, e.ovf);
            check({tag, "_zero"}, zero, e.zero);
`endif
        end
    endtask

    task automatic wait_done(input string tag);
        logic seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        check({tag, "_done_seen"}, seen, 1);
        if (seen) compare_done(tag);
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, done, 0);
    endtask

    initial begin
        logic          exp_order [4];
        exp_t          e;
        int            n_done, n_gnt, t48;
        logic          seen;
        logic [W-1:0]  xr, yr;

        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
        reset = 1'b1;
        req_0 = 1'b0; req_1 = 1'b0; sub_0 = 1'b0; sub_1 = 1'b0;
        x_0 = '0; x_1 = '0; y_0 = '0; y_1 = '0;
        b_req_0 = 1'b0; b_sub_0 = 1'b0; b_x_0 = '0; b_y_0 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", {gnt_1, gnt_0}, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_done_id", done_id, 0);
        check("rst_result", result, 0);
        check("rst_carry", carry, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Carry across the 16-bit slice boundary.
        req_op(1'b0, 32'h0000_FFFF, 32'h0000_0001, 1'b0);
        wait_done("slice_carry");
        check("slice_carry_const", result, 32'h0001_0000);

        // Subtract with and without borrow.
        req_op(1'b1, 32'd5, 32'd7, 1'b1);
        wait_done("sub_borrow");
        check("sub_borrow_const", result, 32'hFFFF_FFFE);
        req_op(1'b1, 32'd7, 32'd5, 1'b1);
        wait_done("sub_noborrow");
        check("sub_noborrow_carry", carry, 1);

        // Full wrap, signed overflow both directions.
        req_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        wait_done("wrap");
        req_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        wait_done("ovf_add");
        req_op(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b1);
        wait_done("ovf_sub");
        for (int i = 0; i < 4; i++) begin
            xr = $urandom;
            yr = $urandom;
            req_op(logic'(i % 2), xr, yr, logic'(i / 2));
            wait_done("rnd");
        end

        // Both requesters held from reset: strict alternation starting at 0.
        reset = 1'b1;
        drive(1'b0, 32'h0000_0100, 32'h0000_0023, 1'b0);
        drive(1'b1, 32'h0000_1000, 32'h0000_0001, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        n_done = 0;
        n_gnt  = 0;
        for (int i = 0; i < 60 && n_done < 4; i++) begin
            @(negedge clk);
            check("rr_one_hot", gnt_0 & gnt_1, 0);
            if ((gnt_0 | gnt_1) && n_gnt < 4) begin
                check("rr_order", gnt_1, exp_order[n_gnt]);
                e   = gnt_1 ? model(32'h0000_1000, 32'h0000_0001, 1'b1, 1'b1)
                            : model(32'h0000_0100, 32'h0000_0023, 1'b0, 1'b0);
                e.t = cyc;
                sb.push_back(e);
                n_gnt++;
            end
            if (done) begin
                compare_done("rr");
                n_done++;
            end
        end
        check("rr_done_count", n_done, 4);
        @(posedge clk);
        #1;
        release_reqs();

        // Reset in the first RUN cycle aborts and restores the pointer.
        req_op(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        check("abort_no_done_0", done, 0);
        @(negedge clk);
        check("abort_no_done_1", done, 0);
        check("abort_busy", busy, 0);
        check("abort_result", result, 0);
        check("abort_carry", carry, 0);
        check("abort_done_id", done_id, 0);
        check("abort_gnt", {gnt_1, gnt_0}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1'b0, 32'h0000_00AA, 32'h0000_0055, 1'b0);
        drive(1'b1, 32'h0000_0001, 32'h0000_0001, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = gnt_0 | gnt_1;
        end
        check("post_rst_gnt_seen", seen, 1);
        check("post_rst_first_gnt", {gnt_1, gnt_0}, 2'b01);
        e   = model(32'h0000_00AA, 32'h0000_0055, 1'b0, 1'b0);
        e.t = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        release_reqs();
        wait_done("post_rst");

        // 48-bit build: three passes, one cycle longer.
        b_req_0 = 1'b1;
        b_x_0   = 48'h0000_FFFF_FFFF;
        b_y_0   = 48'h0000_0000_0001;
        b_sub_0 = 1'b0;
        seen    = 1'b0;
        t48     = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = b_gnt_0;
            t48  = cyc;
        end
        check("w48_gnt_seen", seen, 1);
        @(posedge clk);
        #1;
        b_req_0 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = b_done;
        end
        check("w48_done_seen", seen, 1);
        check("w48_latency", cyc - t48, 4);
        check("w48_result", b_result, 48'h0001_0000_0000);
        check("w48_carry", b_carry, 0);
        check("w48_done_id", b_done_id, 0);
`ifdef CLA_SEQ_FLAGS_EN
        check("w48_zero", b_zero, 0);
        check("w48_overflow", b_ovf, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
